prog_minterm_unit: RTL and testbench

Registered, programmable sum-of-minterms function unit: an N-to-2^N decoder with enable, followed by an OR over a run-time loadable minterm mask. It replaces fixed decoder-plus-OR function blocks (e.g. the 4-input prime detector, minterms 2,3,5,7,11,13) with one pipelined, parametrised block. The block sits between input sampling logic and downstream result/display logic, and keeps a saturating hit count.

---
 rtl/prog_minterm_unit.sv | 174 +++++++++++++++++
 tb/tb_prog_minterm_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_minterm_unit.sv
// prog_minterm_unit: registered N-to-2^N decoder with enable, ORed through a
// run-time loadable minterm mask, plus a saturating hit counter.
//
// The mask is reloaded serially (MSB first) into a shadow register and
// swapped in by a single COMMIT cycle. Evaluation keeps running on the old
// mask throughout the load.
//
// Config FSM states:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | no load in progress; cfg_start begins a new load
//   ST_LOAD   | shifting cfg_bit into the shadow on each cfg_bit_valid cycle
//   ST_COMMIT | one cycle: shadow copied into the live mask, cfg_done high
module prog_minterm_unit #(
   parameter int                N            = 4,
   parameter logic [(1<<N)-1:0] DEFAULT_MASK = 16'h28AC,
   parameter int                CNT_W        = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                in_valid,
   input  logic [N-1:0]        in_sel,
   output logic                out_valid,
   output logic [(1<<N)-1:0]   onehot,
   output logic                f,
   input  logic                cfg_start,
   input  logic                cfg_bit_valid,
   input  logic                cfg_bit,
   output logic                cfg_busy,
   output logic                cfg_done,
   input  logic                cnt_clr,
   output logic [CNT_W-1:0]    hit_cnt
);

   localparam int M = 1 << N;
   localparam logic [N-1:0]     LAST_BIT = '1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } cfg_state_t;

   cfg_state_t     state;
   cfg_state_t     state_nxt;

   logic [M-1:0]   mask;
   logic [M-1:0]   shadow;
   logic [N-1:0]   bit_cnt;

   logic           s1_valid;
   logic           s1_en;
   logic [N-1:0]   s1_sel;
   logic [M-1:0]   dec;

   // Stage 1: capture the request as presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_en    <= 1'b0;
         s1_sel   <= '0;
      end else begin
         s1_valid <= in_valid;
         s1_en    <= en;
         s1_sel   <= in_sel;
      end
   end

   // Decode the captured index; a disabled request decodes to all zeros.
   always_comb begin
      dec = '0;
      if (s1_en) begin
         dec[s1_sel] = 1'b1;
      end
   end

   // Stage 2: register decoder and function result; hold them on bubbles.
   // The mask read here is the pre-edge value, so a result produced on the
   // COMMIT edge still sees the old mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         onehot    <= '0;
         f         <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            onehot <= dec;
            f      <= |(dec & mask);
         end
      end
   end

   // Hit counter: counts presented results with f=1, saturates, clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt <= '0;
      end else if (cnt_clr) begin
         hit_cnt <= '0;
      end else if (out_valid && f && (hit_cnt != CNT_MAX)) begin
         hit_cnt <= hit_cnt + 1'b1;
      end
   end

   // Config FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Config FSM next state and status outputs.
   always_comb begin
      state_nxt = state;
      cfg_busy  = 1'b0;
      cfg_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cfg_start) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cfg_busy = 1'b1;
            if (cfg_bit_valid && (bit_cnt == LAST_BIT)) begin
               state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            cfg_busy  = 1'b1;
            cfg_done  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Shadow shift register, accepted-bit counter and live mask update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask    <= DEFAULT_MASK;
         shadow  <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_start) begin
                  shadow  <= '0;
                  bit_cnt <= '0;
               end
            end
            ST_LOAD: begin
               if (cfg_bit_valid) begin
                  shadow  <= {shadow[M-2:0], cfg_bit};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_COMMIT: begin
               mask <= shadow;
            end
            default: begin
               shadow <= shadow;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_minterm_unit.sv
// Bench for prog_minterm_unit: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_prog_minterm_unit;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        in_valid;
   logic [3:0]  in_sel;
   logic        cfg_start;
   logic        cfg_bit_valid;
   logic        cfg_bit;
   logic        cnt_clr;

   logic        out_valid,  out_valid2;
   logic [15:0] onehot,     onehot2;
   logic        f,          f2;
   logic        cfg_busy,   cfg_busy2;
   logic        cfg_done,   cfg_done2;
   logic [7:0]  hit_cnt;
   logic [1:0]  hit_cnt2;

   int n_pass  = 0;
   int n_total = 0;

   prog_minterm_unit #(.N(4), .DEFAULT_MASK(16'h28AC), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_sel(in_sel),
      .out_valid(out_valid), .onehot(onehot), .f(f),
      .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid), .cfg_bit(cfg_bit),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
   );

   prog_minterm_unit #(.N(4), .DEFAULT_MASK(16'h28AC), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_sel(in_sel),
      .out_valid(out_valid2), .onehot(onehot2), .f(f2),
      .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid), .cfg_bit(cfg_bit),
      .cfg_busy(cfg_busy2), .cfg_done(cfg_done2), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic is_prime(input int s);
      return (s == 2) || (s == 3) || (s == 5) || (s == 7) || (s == 11) || (s == 13);
   endfunction

   // ---------------- behavioural model ----------------
   logic [15:0] m_mask;
   int          m_shadow;
   int          m_nbits;
   bit          m_loading, m_committing;
   bit          p_valid, p_en;
   int          p_sel;
   bit          e_valid, e_f;
   logic [15:0] e_onehot;
   int          e_cnt, e_cnt2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mask = 16'h28AC; m_shadow = 0; m_nbits = 0;
         m_loading = 0; m_committing = 0;
         p_valid = 0; p_en = 0; p_sel = 0;
         e_valid = 0; e_f = 0; e_onehot = 16'h0;
         e_cnt = 0; e_cnt2 = 0;
      end else begin
         // counter reacts to the result presented on the previous edge
         if (cnt_clr) begin
            e_cnt = 0; e_cnt2 = 0;
         end else if (e_valid && e_f) begin
            if (e_cnt < 255) e_cnt++;
            if (e_cnt2 < 3) e_cnt2++;
         end
         // result for the request captured one edge ago, using the current mask
         e_valid = p_valid;
         if (p_valid) begin
            e_onehot = p_en ? (16'h1 << p_sel) : 16'h0;
            e_f      = p_en && m_mask[p_sel];
         end
         p_valid = in_valid; p_en = en; p_sel = int'(in_sel);
         // mask loading
         if (m_committing) begin
            m_mask = m_shadow[15:0];
            m_committing = 0;
         end else if (m_loading) begin
            if (cfg_bit_valid) begin
               m_shadow = ((m_shadow << 1) | int'(cfg_bit)) & 32'hFFFF;
               m_nbits++;
               if (m_nbits == 16) begin
                  m_loading = 0; m_committing = 1;
               end
            end
         end else if (cfg_start) begin
            m_loading = 1; m_nbits = 0; m_shadow = 0;
         end
      end
   end

   // Per-cycle compare against the model, just after each active edge.
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("out_valid", out_valid, e_valid);
         if (e_valid) begin
            chk("onehot", onehot, e_onehot);
            chk("f", f, e_f);
         end
         chk("cfg_busy", cfg_busy, m_loading || m_committing);
         chk("cfg_done", cfg_done, m_committing);
         chk("hit_cnt", hit_cnt, e_cnt);
         chk("hit_cnt_sat", hit_cnt2, e_cnt2);
      end
   end

   // Serial mask load; evaluation inputs are left as the caller set them
   // (held valid with a fixed in_sel), and a stall follows minterm bit 5.
   task automatic load_mask(input logic [15:0] val, input logic exp_old);
      logic new_bit;
      new_bit = val[in_sel];
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      chk("busy_after_start", cfg_busy, 1'b1);
      for (int i = 15; i >= 0; i--) begin
         cfg_bit_valid = 1'b1; cfg_bit = val[i]; tick();
         if (i == 8) chk("f_during_load", f, exp_old);
         if (i == 5) begin
            cfg_bit_valid = 1'b0; tick();
            chk("busy_in_stall", cfg_busy, 1'b1);
         end
      end
      cfg_bit_valid = 1'b0;
      chk("done_after_16", cfg_done, 1'b1);
      tick();
      chk("done_one_cycle", cfg_done, 1'b0);
      chk("f_on_commit_edge", f, exp_old);
      tick();
      chk("f_after_commit", f, new_bit);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_sel = 4'd0;
      cfg_start = 1'b0; cfg_bit_valid = 1'b0; cfg_bit = 1'b0; cnt_clr = 1'b0;
      tick(); tick();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_onehot", onehot, 16'h0000);
      chk("rst_f", f, 1'b0);
      chk("rst_busy", cfg_busy, 1'b0);
      chk("rst_done", cfg_done, 1'b0);
      chk("rst_hit_cnt", hit_cnt, 8'd0);
      rst_n = 1'b1; tick(); tick();

      // default-mask sweep, back-to-back
      for (int s = 0; s < 16; s++) begin
         in_valid = 1'b1; en = 1'b1; in_sel = 4'(s); tick();
         if (s > 0) begin
            chk("sweep_valid", out_valid, 1'b1);
            chk("sweep_onehot", onehot, 32'h1 << (s - 1));
            chk("sweep_f", f, is_prime(s - 1));
         end
      end
      in_valid = 1'b0; tick();
      chk("sweep_onehot_15", onehot, 16'h8000);
      chk("sweep_f_15", f, 1'b0);
      tick(); tick();
      chk("sweep_hits", hit_cnt, 8'd6);
      chk("sweep_hits_sat", hit_cnt2, 2'd3);

      // disabled decode
      in_valid = 1'b1; en = 1'b0; in_sel = 4'd3; tick();
      in_valid = 1'b0; en = 1'b1; tick();
      chk("en0_valid", out_valid, 1'b1);
      chk("en0_onehot", onehot, 16'h0000);
      chk("en0_f", f, 1'b0);
      tick(); tick();
      chk("en0_hits", hit_cnt, 8'd6);

      // load 16'h8001 while evaluating minterm 2
      in_valid = 1'b1; en = 1'b1; in_sel = 4'd2;
      load_mask(16'h8001, 1'b1);
      in_sel = 4'd0; tick();
      in_sel = 4'd15; tick();
      chk("m8001_sel0", f, 1'b1);
      in_sel = 4'd2; tick();
      chk("m8001_sel15", f, 1'b1);
      in_valid = 1'b0; tick();
      chk("m8001_sel2", f, 1'b0);
      tick(); tick();

      // saturation and clear priority
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      in_valid = 1'b1; in_sel = 4'd0;
      for (int k = 0; k < 5; k++) tick();
      in_valid = 1'b0; tick(); tick(); tick();
      chk("five_hits", hit_cnt, 8'd5);
      chk("five_hits_sat", hit_cnt2, 2'd3);
      in_valid = 1'b1; tick(); tick();
      cnt_clr = 1'b1; tick();
      chk("clr_wins", hit_cnt, 8'd0);
      chk("clr_wins_sat", hit_cnt2, 2'd0);
      cnt_clr = 1'b0; in_valid = 1'b0; tick();
      chk("count_after_clr", hit_cnt, 8'd1);
      tick(); tick();

      // restore a mask with minterm 2 set, then commit boundary to 16'h0000
      in_valid = 1'b1; in_sel = 4'd2;
      load_mask(16'h28AC, 1'b0);
      load_mask(16'h0000, 1'b1);
      in_valid = 1'b0; tick(); tick();

      // reset in the middle of a load
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cfg_bit_valid = 1'b1; cfg_bit = 1'b0; tick();
      end
      cfg_bit_valid = 1'b0;
      rst_n = 1'b0; #1;
      chk("midrst_busy", cfg_busy, 1'b0);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_hits", hit_cnt, 8'd0);
      tick(); rst_n = 1'b1;
      in_valid = 1'b1; en = 1'b1; in_sel = 4'd13; tick();
      in_valid = 1'b0; tick();
      chk("midrst_sel13_valid", out_valid, 1'b1);
      chk("midrst_sel13_f", f, 1'b1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         en            = ($urandom_range(0, 7) != 0);
         in_sel        = 4'($urandom_range(0, 15));
         cfg_start     = ($urandom_range(0, 39) == 0);
         cfg_bit_valid = ($urandom_range(0, 3) != 0);
         cfg_bit       = 1'($urandom);
         cnt_clr       = ($urandom_range(0, 99) == 0);
         tick();
      end
      in_valid = 1'b0; cfg_start = 1'b0; cfg_bit_valid = 1'b0; cnt_clr = 1'b0;
      tick(); tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
